// File: rtl/synapse_bram_ctrl_if.sv
// Bus bundle between the synapse BRAM controller, its two requesters and the BRAM.
// The slave modport is the controller's view; master is the requester/BRAM side.
interface synapse_bram_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_w_en;
  logic [DATA_W-1:0] bram_q;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_q,
    output wr_ack, rd_ack, rd_valid, rd_data, bram_addr, bram_data, bram_w_en
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_q,
    input  wr_ack, rd_ack, rd_valid, rd_data, bram_addr, bram_data, bram_w_en
  );
endinterface

// File: rtl/synapse_bram_ctrl.sv
// Round-robin arbiter between weight-loader writes and neuron reads on a single-port
// synapse BRAM, plus a full-table clear sweep started by a kill pulse.
module synapse_bram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  synapse_bram_ctrl_if.slave  bus,
  output logic                busy,
  output logic                clr_done
);
  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  logic              r_rr_wr, w_rr_wr_next;
  logic [ADDR_W-1:0] r_bram_addr, w_bram_addr_next;
  logic [DATA_W-1:0] r_bram_data, w_bram_data_next;
  logic              r_bram_w_en, w_bram_w_en_next;
  logic              r_wr_ack, w_wr_ack_next;
  logic              r_rd_ack, w_rd_ack_next;
  logic              r_rd_valid;
  logic              r_busy, w_busy_next;
  logic              r_clr_done, w_clr_done_next;
  logic              w_wr_elig, w_rd_elig;

  // A requester whose ack is showing this cycle is still holding req; mask it.
  assign w_wr_elig = bus.wr_req & ~r_wr_ack;
  assign w_rd_elig = bus.rd_req & ~r_rd_ack;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_rr_wr_next     = r_rr_wr;
    w_bram_addr_next = r_bram_addr;
    w_bram_data_next = r_bram_data;
    w_bram_w_en_next = 1'b0;
    w_wr_ack_next    = 1'b0;
    w_rd_ack_next    = 1'b0;
    w_busy_next      = r_busy;
    w_clr_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (kill) begin
          w_state_next = ST_CLEAR;
          w_cnt_next   = '0;
          w_busy_next  = 1'b1;
        end else if (w_wr_elig && (!w_rd_elig || r_rr_wr)) begin
          w_bram_addr_next = bus.wr_addr;
          w_bram_data_next = bus.wr_data;
          w_bram_w_en_next = 1'b1;
          w_wr_ack_next    = 1'b1;
          if (w_rd_elig) w_rr_wr_next = 1'b0;
        end else if (w_rd_elig) begin
          w_bram_addr_next = bus.rd_addr;
          w_rd_ack_next    = 1'b1;
          if (w_wr_elig) w_rr_wr_next = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_bram_addr_next = r_cnt;
        w_bram_data_next = '0;
        w_bram_w_en_next = 1'b1;
        w_cnt_next       = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_next    = ST_IDLE;
          w_cnt_next      = '0;
          w_clr_done_next = 1'b1;
          w_busy_next     = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rr_wr     <= 1'b1;
      r_bram_addr <= '0;
      r_bram_data <= '0;
      r_bram_w_en <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_clr_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_rr_wr     <= w_rr_wr_next;
      r_bram_addr <= w_bram_addr_next;
      r_bram_data <= w_bram_data_next;
      r_bram_w_en <= w_bram_w_en_next;
      r_wr_ack    <= w_wr_ack_next;
      r_rd_ack    <= w_rd_ack_next;
      // BRAM output lands one edge after the read address, independent of state.
      r_rd_valid  <= r_rd_ack;
      r_busy      <= w_busy_next;
      r_clr_done  <= w_clr_done_next;
    end
  end

  assign bus.wr_ack    = r_wr_ack;
  assign bus.rd_ack    = r_rd_ack;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = bus.bram_q;
  assign bus.bram_addr = r_bram_addr;
  assign bus.bram_data = r_bram_data;
  assign bus.bram_w_en = r_bram_w_en;
  assign busy          = r_busy;
  assign clr_done      = r_clr_done;
endmodule

// File: tb/tb_synapse_bram_ctrl.sv
// Bench for synapse_bram_ctrl: BRAM model, transaction-level weight model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_synapse_bram_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst;
  logic kill;
  logic busy;
  logic clr_done;

  synapse_bram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  synapse_bram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .kill     (kill),
    .bus      (bus),
    .busy     (busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  // Single-port BRAM: write on w_en, registered read.
  bit [7:0] bram_mem [DEPTH];
  bit [7:0] bram_q_r;
  always @(posedge clk) begin
    if (bus.bram_w_en) bram_mem[bus.bram_addr] <= bus.bram_data;
    bram_q_r <= bram_mem[bus.bram_addr];
  end
  assign bus.bram_q = bram_q_r;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected weight table, updated from acknowledged transactions and sweeps.
  bit [7:0] exp_mem [DEPTH];
  bit       prev_rd_ack = 1'b0;
  bit       prev_busy   = 1'b0;
  logic [7:0] rd_exp = '0;
  int busy_run = 0;
  int last_busy_run = 0;
  int clr_count = 0;
  int cyc = 0;
  bit log_en = 1'b0;
  int gidx = 0;
  byte gkind [64];
  int  gcyc  [64];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("reset_outs", {bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.bram_w_en,
                           bus.bram_addr, bus.bram_data, busy, clr_done}, 32'h0);
    end
    check("rd_valid", bus.rd_valid, prev_rd_ack && !rst);
    if (bus.rd_valid) check("rd_data", bus.rd_data, rd_exp);
    if (bus.wr_ack) begin
      check("wr_bus", {bus.bram_w_en, bus.bram_addr, bus.bram_data},
            {1'b1, bus.wr_addr, bus.wr_data});
      check("wr_excl", {bus.rd_ack, busy}, 32'h0);
      exp_mem[bus.wr_addr] = bus.wr_data;
      if (log_en && gidx < 64) begin gkind[gidx] = "W"; gcyc[gidx] = cyc; gidx++; end
    end
    if (bus.rd_ack) begin
      check("rd_bus", {bus.bram_w_en, bus.bram_addr}, {1'b0, bus.rd_addr});
      check("rd_excl", busy, 1'b0);
      rd_exp = exp_mem[bus.rd_addr];
      if (log_en && gidx < 64) begin gkind[gidx] = "R"; gcyc[gidx] = cyc; gidx++; end
    end
    if (busy) begin
      if (busy_run == 0) check("sweep_start_wen", bus.bram_w_en, 1'b0);
      else check("sweep_write", {bus.bram_w_en, bus.bram_addr, bus.bram_data},
                 {1'b1, 8'(busy_run - 1), 8'h00});
      busy_run++;
    end
    check("clr_done", clr_done, prev_busy && !busy && !rst);
    if (prev_busy && !busy) begin
      if (rst) begin
        for (int i = 0; i < busy_run - 1; i++) exp_mem[i] = 8'h00;
      end else begin
        check("busy_len", busy_run, DEPTH);
        check("sweep_last", {bus.bram_w_en, bus.bram_addr, bus.bram_data}, {1'b1, 8'hFF, 8'h00});
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
        clr_count++;
      end
      last_busy_run = busy_run;
      busy_run = 0;
    end
    prev_rd_ack = bus.rd_ack;
    prev_busy   = busy;
  end

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, output int lat);
    bit got = 1'b0;
    lat = 0;
    bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      if (bus.wr_ack) begin got = 1'b1; lat = n + 1; break; end
    end
    bus.wr_req = 1'b0;
    check("wr_ack_timeout", got, 1'b1);
    $display("[TB] WR addr=0x%02h data=0x%02h lat=%0d", a, d, lat);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output int lat);
    bit got = 1'b0;
    lat = 0;
    bus.rd_addr = a; bus.rd_req = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      if (bus.rd_ack) begin got = 1'b1; lat = n + 1; break; end
    end
    bus.rd_req = 1'b0;
    check("rd_ack_timeout", got, 1'b1);
    @(negedge clk); #1;
    check("rd_valid_follow", bus.rd_valid, 1'b1);
    d = bus.rd_data;
    $display("[TB] RD addr=0x%02h data=0x%02h lat=%0d", a, d, lat);
  endtask

  task automatic kill_pulse();
    kill = 1'b1;
    @(negedge clk); #1;
    kill = 1'b0;
  endtask

  logic [7:0] rd_d, rd_d2;
  int lat, lat2, clr0;

  initial begin
    rst = 1'b1; kill = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset_state", {busy, clr_done, bus.bram_w_en, bus.bram_addr, bus.bram_data,
                          bus.wr_ack, bus.rd_ack, bus.rd_valid}, 32'h0);

    // Single write: one-cycle latency, one-cycle BRAM write strobe.
    do_write(8'h05, 8'hA7, lat);
    check("wr_latency", lat, 1);
    check("wr1_bram", {bus.bram_w_en, bus.bram_addr, bus.bram_data}, {1'b1, 8'h05, 8'hA7});
    @(negedge clk); #1;
    check("wr1_wen_pulse", bus.bram_w_en, 1'b0);

    do_read(8'h05, rd_d, lat);
    check("rd_0x05", rd_d, 8'hA7);
    check("rd_latency", lat, 1);

    // Read of the same address granted the edge after the write.
    fork
      do_write(8'h07, 8'h3C, lat);
      begin
        @(negedge clk); #1;
        do_read(8'h07, rd_d2, lat2);
      end
    join
    check("raw_data", rd_d2, 8'h3C);
    check("raw_latency", lat2, 1);

    // Fresh reset, then both sides held: W,R,W,R on consecutive cycles.
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    gidx = 0; log_en = 1'b1;
    fork
      for (int i = 0; i < 5; i++) do_write(8'h40 + 8'(i), 8'hC0 + 8'(i), lat);
      for (int i = 0; i < 5; i++) do_read(8'h40 + 8'(i), rd_d, lat2);
    join
    log_en = 1'b0;
    check("alt_count", gidx, 10);
    for (int i = 0; i < 10; i++) begin
      check("alt_kind", gkind[i], (i % 2 == 0) ? 8'("W") : 8'("R"));
      check("alt_cycle", gcyc[i] - gcyc[0], i);
    end

    // Kill with a read pending: read served only after the full sweep.
    clr0 = clr_count;
    kill = 1'b1;
    fork
      do_read(8'h05, rd_d, lat);
      begin @(negedge clk); #1; kill = 1'b0; end
    join
    check("kill_rd_data", rd_d, 8'h00);
    check("kill_rd_latency", lat, 258);
    check("kill_clr_count", clr_count, clr0 + 1);
    check("kill_busy_len", last_busy_run, 256);

    // Second kill mid-sweep is ignored.
    clr0 = clr_count;
    kill_pulse();
    repeat (99) @(negedge clk);
    #1 kill_pulse();
    for (int n = 0; n < 400 && clr_count == clr0; n++) begin
      @(negedge clk); #1;
    end
    check("rekill_clr_count", clr_count, clr0 + 1);
    check("rekill_busy_len", last_busy_run, 256);
    repeat (5) @(negedge clk);
    #1 check("rekill_no_restart", busy, 1'b0);

    // Reset partway through a sweep aborts it.
    do_write(8'h10, 8'h77, lat);
    do_write(8'h80, 8'h99, lat);
    clr0 = clr_count;
    kill_pulse();
    repeat (49) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("abort_outs", {busy, bus.bram_w_en, clr_done}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("abort_no_clr_done", clr_count, clr0);
    do_read(8'h10, rd_d, lat);
    check("abort_rd_0x10", rd_d, 8'h00);
    do_read(8'h80, rd_d, lat);
    check("abort_rd_0x80", rd_d, 8'h99);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
